// File: rtl/kypd_scan.sv
// kypd_scan: 4x4 matrix keypad scanner with frame-level debounce.
//   clk        system clock, all registers on the rising edge
//   rst        synchronous active-high reset
//   row_n[3:0] keypad rows, pulled up, low = pressed on the driven column
//   col_n[3:0] keypad column drive, active-low, at most one bit low
//   key_code   hex code of the last debounced key
//   key_valid  one-cycle pulse when a new key becomes the debounced state
//   key_held   high while the debounced state is a key
module kypd_scan #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 2);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        DRIVE  = 2'd0,
        SAMPLE = 2'd1,
        EVAL   = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [1:0]       col_idx, col_idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [3:0]       row_s1, row_s2;
    logic [3:0]       slot [4];

    logic [3:0]       col_n_c;
    logic             sample_c;
    logic             eval_c;

    logic [4:0]       low_cnt;
    logic [3:0]       low_pos;
    logic [4:0]       res;          // {is_key, code}; all zero means NONE

    logic [4:0]       cand, cand_n;
    logic [DEB_W-1:0] match, match_n;
    logic [4:0]       stable;
    logic             promote_c;

    // Key legend, indexed by row*4 + col.
    function automatic logic [3:0] key_map(input logic [3:0] pos);
        case (pos)
            4'd0:    return 4'h1;
            4'd1:    return 4'h2;
            4'd2:    return 4'h3;
            4'd3:    return 4'hA;
            4'd4:    return 4'h4;
            4'd5:    return 4'h5;
            4'd6:    return 4'h6;
            4'd7:    return 4'hB;
            4'd8:    return 4'h7;
            4'd9:    return 4'h8;
            4'd10:   return 4'h9;
            4'd11:   return 4'hC;
            4'd12:   return 4'h0;
            4'd13:   return 4'hF;
            4'd14:   return 4'hE;
            default: return 4'hD;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DRIVE;
            col_idx <= 2'd0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            col_idx <= col_idx_n;
            cnt     <= cnt_n;
        end
    end

    // Next-state logic: SCAN_DIV-1 drive cycles plus one sample cycle per column.
    always_comb begin
        state_n   = state;
        col_idx_n = col_idx;
        cnt_n     = cnt;
        case (state)
            DRIVE: begin
                if (cnt == CNT_LAST) begin
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (col_idx == 2'd3) begin
                    state_n = EVAL;
                end else begin
                    state_n   = DRIVE;
                    col_idx_n = col_idx + 2'd1;
                    cnt_n     = '0;
                end
            end
            default: begin
                state_n   = DRIVE;
                col_idx_n = 2'd0;
                cnt_n     = '0;
            end
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        col_n_c  = 4'hF;
        sample_c = 1'b0;
        eval_c   = 1'b0;
        case (state)
            DRIVE: begin
                col_n_c[col_idx] = 1'b0;
            end
            SAMPLE: begin
                col_n_c[col_idx] = 1'b0;
                sample_c         = 1'b1;
            end
            EVAL: begin
                eval_c = 1'b1;
            end
            default: begin
                col_n_c = 4'hF;
            end
        endcase
    end

    // Row synchroniser and per-column capture; idle level is all rows released.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                slot[i] <= 4'hF;
            end
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
            if (sample_c) begin
                slot[col_idx] <= row_s2;
            end
        end
    end

    // Frame result: a key only when exactly one of the 16 contacts is closed.
    always_comb begin
        low_cnt = '0;
        low_pos = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!slot[c][r]) begin
                    low_cnt = low_cnt + 5'd1;
                    low_pos = 4'(r * 4 + c);
                end
            end
        end
        res = (low_cnt == 5'd1) ? {1'b1, key_map(low_pos)} : 5'd0;
    end

    // Debounce: count consecutive identical frame results, saturating.
    always_comb begin
        cand_n  = res;
        match_n = DEB_W'(1);
        if (res == cand) begin
            cand_n  = cand;
            match_n = (match == DEB_MAX) ? match : match + DEB_W'(1);
        end
        promote_c = (match_n == DEB_MAX) && (cand_n != stable);
    end

    // Registered outputs and debounce state, updated on the evaluation cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_n     <= 4'hF;
            cand      <= '0;
            match     <= '0;
            stable    <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            col_n     <= col_n_c;
            key_valid <= 1'b0;
            if (eval_c) begin
                cand  <= cand_n;
                match <= match_n;
                if (promote_c) begin
                    stable   <= cand_n;
                    key_held <= cand_n[4];
                    if (cand_n[4]) begin
                        key_code  <= cand_n[3:0];
                        key_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_kypd_scan.sv
// tb_kypd_scan: directed and random keypad stimulus against a frame-level
// reference model (per-frame result plus a debounce window of recent frames).
module tb_kypd_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;
    localparam int FRAME    = 4 * SCAN_DIV + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] press = '0;     // pressed contacts, bit row*4+col

    always #5 clk = ~clk;

    kypd_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Passive keypad: a pressed contact pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (press[r * 4 + c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'h0, 4'hF, 4'hE, 4'hD};

    int         vectors     = 0;
    int         miscompares = 0;
    int         t           = 0;
    int         pulses      = 0;

    logic [4:0] hist [$];
    logic [4:0] m_stable = '0;
    logic [3:0] m_code   = '0;
    logic       m_held   = 1'b0;
    logic       m_valid  = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [15:0] kbit(input int r, input int c);
        logic [15:0] one = 16'd1;
        return one << (r * 4 + c);
    endfunction

    task automatic model_reset();
        hist.delete();
        m_stable = '0;
        m_code   = '0;
        m_held   = 1'b0;
        m_valid  = 1'b0;
        t        = 0;
    endtask

    // One frame finished: classify it and apply the debounce window.
    task automatic frame_eval();
        logic [4:0] res;
        bit         same;
        res = '0;
        if ($countones(press) == 1) begin
            for (int i = 0; i < 16; i++) if (press[i]) res = {1'b1, kmap[i]};
        end
        hist.push_back(res);
        if (hist.size() > DEB) void'(hist.pop_front());
        if (hist.size() == DEB) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
            if (same && hist[0] != m_stable) begin
                m_stable = hist[0];
                m_held   = m_stable[4];
                if (m_stable[4]) begin
                    m_code  = m_stable[3:0];
                    m_valid = 1'b1;
                end
            end
        end
    endtask

    // Advance one clock and check every output against the model.
    task automatic step();
        int         pos;
        logic [3:0] one;
        logic [3:0] exp_col;
        one = 4'b0001;
        @(posedge clk);
        #1;
        pos     = t % FRAME;
        m_valid = 1'b0;
        if (pos == FRAME - 1) frame_eval();
        exp_col = (pos < FRAME - 1) ? ~(one << (pos / SCAN_DIV)) : 4'hF;
        chk("col_n",     int'(col_n),     int'(exp_col));
        chk("key_valid", int'(key_valid), int'(m_valid));
        chk("key_held",  int'(key_held),  int'(m_held));
        chk("key_code",  int'(key_code),  int'(m_code));
        if (key_valid) pulses++;
        t++;
    endtask

    task automatic play(input logic [15:0] mask, input int nframes);
        press = mask;
        repeat (nframes * FRAME) step();
    endtask

    task automatic play_part(input logic [15:0] mask, input int ncyc);
        press = mask;
        repeat (ncyc) step();
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        repeat (ncyc) begin
            @(posedge clk);
            #1;
            chk("rst_col_n",     int'(col_n),     'hF);
            chk("rst_key_valid", int'(key_valid), 0);
            chk("rst_key_held",  int'(key_held),  0);
            chk("rst_key_code",  int'(key_code),  0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mask;
        int          sel;
        int          a;
        int          b;

        // Reset and idle scanning.
        do_reset(3);
        play('0, 2);

        // Single press of '5', then release.
        pulses = 0;
        play(kbit(1, 1), 4);
        chk("held_5", int'(key_held), 1);
        play('0, 3);
        chk("pulses_5", pulses, 1);
        chk("released_5", int'(key_held), 0);

        // '9' bouncing every frame.
        pulses = 0;
        for (int f = 0; f < 6; f++) play((f % 2 == 0) ? kbit(2, 2) : 16'h0, 1);
        chk("pulses_bounce", pulses, 0);
        chk("held_bounce", int'(key_held), 0);
        play('0, 1);

        // '1' and '2' together.
        pulses = 0;
        play(kbit(0, 0) | kbit(0, 1), 4);
        chk("pulses_multi", pulses, 0);
        chk("held_multi", int'(key_held), 0);
        play('0, 1);

        // 'A' then straight to '0'.
        pulses = 0;
        play(kbit(0, 3), 3);
        chk("code_A", int'(key_code), 'hA);
        play(kbit(3, 0), 3);
        chk("code_0", int'(key_code), 'h0);
        chk("held_change", int'(key_held), 1);
        chk("pulses_change", pulses, 2);
        play('0, 2);

        // 'D' stable, reset mid-frame, fresh pulse two frames later.
        pulses = 0;
        play(kbit(3, 3), 3);
        play_part(kbit(3, 3), 8);
        do_reset(1);
        play(kbit(3, 3), 2);
        chk("pulses_rst", pulses, 2);
        chk("code_D", int'(key_code), 'hD);
        play('0, 2);

        // Random presses, multi-presses, holds and occasional resets.
        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 9));
            a   = int'($urandom_range(0, 15));
            b   = (a + int'($urandom_range(1, 15))) % 16;
            if (sel < 3)      mask = '0;
            else if (sel < 8) mask = kbit(a / 4, a % 4);
            else              mask = kbit(a / 4, a % 4) | kbit(b / 4, b % 4);
            if ($urandom_range(0, 9) == 0) begin
                play_part(mask, int'($urandom_range(1, FRAME - 1)));
                do_reset(int'($urandom_range(1, 3)));
            end
            play(mask, int'($urandom_range(1, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
